// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with optional parity and registered one-cycle outcome pulses.
// Define UART_RX_MAJORITY_EN to decide each bit by 2-of-3 vote around mid-bit.
module uart_rx #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx_in,
   input  logic [5:0]            prescale,
   input  logic                  par_en,
   input  logic                  par_typ,
   output logic [DATA_WIDTH-1:0] p_data,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stp_err,
   output logic                  busy
);
   localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   state_t state;
   logic rx_s1, rx;
   logic [5:0] pre_eff, pre_l, half, edge_cnt;
   logic [BW-1:0] bit_cnt;
   logic [DATA_WIDTH-1:0] shift;
   logic par_en_l, par_typ_l, par_bad, brk, s_mid, vote, wrap, decide;
   always_ff @(posedge clk or posedge rst)
      if (rst) {rx_s1, rx} <= 2'b11;
      else {rx_s1, rx} <= {rx_in, rx_s1};
   always_comb begin
      pre_eff = prescale < 6'd8 ? 6'd8 : {prescale[5:1], 1'b0};
      half = {1'b0, pre_l[5:1]};
      wrap = edge_cnt == pre_l - 6'd1;
      decide = edge_cnt == half + 6'd1;
   end
`ifdef UART_RX_MAJORITY_EN
   logic s_lo;
   always_ff @(posedge clk or posedge rst)
      if (rst) s_lo <= 1'b1;
      else if (edge_cnt == half - 6'd1) s_lo <= rx;
   always_comb vote = (s_lo & s_mid) | (s_lo & rx) | (s_mid & rx);
`else
   always_comb vote = s_mid;
`endif
   // Bit decisions land one cycle after the mid-bit sample (edge count half+1) in both builds.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         edge_cnt <= '0;
         bit_cnt <= '0;
         shift <= '0;
         pre_l <= 6'd8;
         par_en_l <= 1'b0;
         par_typ_l <= 1'b0;
         par_bad <= 1'b0;
         brk <= 1'b0;
         s_mid <= 1'b1;
         p_data <= '0;
         data_valid <= 1'b0;
         par_err <= 1'b0;
         stp_err <= 1'b0;
         busy <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         par_err <= 1'b0;
         stp_err <= 1'b0;
         if (rx) brk <= 1'b0;
         if (state != IDLE) begin
            edge_cnt <= wrap ? '0 : edge_cnt + 6'd1;
            if (edge_cnt == half) s_mid <= rx;
         end
         case (state)
            IDLE:
               if (!rx && !brk) begin
                  state <= START;
                  busy <= 1'b1;
                  edge_cnt <= '0;
                  bit_cnt <= '0;
                  par_bad <= 1'b0;
                  pre_l <= pre_eff;
                  par_en_l <= par_en;
                  par_typ_l <= par_typ;
               end
            START:
               if (decide && vote) begin
                  state <= IDLE;
                  busy <= 1'b0;
               end else if (wrap) state <= DATA;
            DATA: begin
               if (decide) shift <= {vote, shift[DATA_WIDTH-1:1]};
               if (wrap) begin
                  bit_cnt <= bit_cnt + BW'(1);
                  if (bit_cnt == BW'(DATA_WIDTH - 1)) state <= par_en_l ? PARITY : STOP;
               end
            end
            PARITY: begin
               if (decide) par_bad <= vote != (^shift ^ par_typ_l);
               if (wrap) state <= STOP;
            end
            STOP:
               if (decide) begin
                  data_valid <= vote && !par_bad;
                  par_err <= par_bad;
                  stp_err <= !vote;
                  if (vote && !par_bad) p_data <= shift;
                  if (!vote) brk <= 1'b1;
               end else if (edge_cnt == half + 6'd2) begin
                  state <= IDLE;
                  busy <= 1'b0;
               end
            default: begin
               state <= IDLE;
               busy <= 1'b0;
            end
         endcase
      end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table vectors, hand sequences and random frames checked against a frame-level model.
module tb_uart_rx;
   logic clk = 1'b0, rst = 1'b1, rx_in = 1'b1, par_en = 1'b0, par_typ = 1'b0;
   logic [5:0] prescale = 6'd16;
   logic [7:0] p_data;
   logic data_valid, par_err, stp_err, busy;
   int total = 0, bad = 0;
   int n_dv = 0, n_pe = 0, n_se = 0, n_busy = 0;
   logic [7:0] pd_q[$];
   logic [7:0] exp_pd = 8'h00;
   uart_rx #(.DATA_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .rx_in(rx_in), .prescale(prescale), .par_en(par_en),
      .par_typ(par_typ), .p_data(p_data), .data_valid(data_valid), .par_err(par_err),
      .stp_err(stp_err), .busy(busy)
   );
   always #5 clk = ~clk;
   always @(negedge clk) begin
      if (data_valid) begin
         n_dv++;
         pd_q.push_back(p_data);
      end
      if (par_err) n_pe++;
      if (stp_err) n_se++;
      if (busy) n_busy++;
   end
   typedef struct {
      logic [7:0] d;
      logic [5:0] pin;
      logic pen, ptyp, pbit, sbit;
      logic edv, epe, ese;
      logic [7:0] epd;
   } vec_t;
   vec_t tbl[6];
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         rx_in = 1'b1;
      end
   endtask
   task automatic send_bit(input logic b, input int pre, input int flip);
      for (int i = 0; i < pre; i++) begin
         @(negedge clk);
         rx_in = (i == flip) ? ~b : b;
      end
   endtask
   task automatic send_frame(input logic [7:0] d, input int pre, input logic pen, input logic pbit,
                             input logic sbit, input int flip);
      send_bit(1'b0, pre, -1);
      for (int i = 0; i < 8; i++) send_bit(d[i], pre, flip);
      if (pen) send_bit(pbit, pre, -1);
      send_bit(sbit, pre, -1);
   endtask
   function automatic int eff_pre(input logic [5:0] pin);
      return pin < 6'd8 ? 8 : int'(pin) / 2 * 2;
   endfunction
   task automatic run_frame(input string tag, input logic [7:0] d, input logic [5:0] pin,
                            input logic pen, input logic ptyp, input logic pbit, input logic sbit,
                            input int flip, input logic edv, input logic epe, input logic ese,
                            input logic [7:0] epd);
      int dv0 = n_dv, pe0 = n_pe, se0 = n_se, pre;
      pre = eff_pre(pin);
      prescale = pin;
      par_en = pen;
      par_typ = ptyp;
      send_frame(d, pre, pen, pbit, sbit, flip);
      idle(3 * pre);
      check({tag, ".dv"}, n_dv - dv0, {31'd0, edv});
      check({tag, ".pe"}, n_pe - pe0, {31'd0, epe});
      check({tag, ".se"}, n_se - se0, {31'd0, ese});
      check({tag, ".pd"}, p_data, epd);
      check({tag, ".busy"}, busy, 0);
   endtask
   task automatic model_frame(input string tag, input logic [7:0] d, input logic [5:0] pin,
                              input logic pen, input logic ptyp, input logic pbit, input logic sbit,
                              input int flip);
      logic ep, es, ev;
      ep = pen && (pbit != ((^d) ^ ptyp));
      es = !sbit;
      ev = !ep && !es;
      if (ev) exp_pd = d;
      run_frame(tag, d, pin, pen, ptyp, pbit, sbit, flip, ev, ep, es, exp_pd);
   endtask
   initial begin
      int dv0, pe0, se0, b0, q0;
      tbl[0] = '{8'hA5, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5};
      tbl[1] = '{8'h3C, 6'd8,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5};
      tbl[2] = '{8'h81, 6'd16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5};
      tbl[3] = '{8'h5A, 6'd5,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h5A};
      tbl[4] = '{8'hC3, 6'd17, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A};
      tbl[5] = '{8'h00, 6'd32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
      repeat (3) @(negedge clk);
      rst = 1'b0;
      idle(4);
      check("reset.busy", busy, 0);
      check("reset.pd", p_data, 0);
      check("reset.pulses", {data_valid, par_err, stp_err}, 0);
      foreach (tbl[i])
         run_frame($sformatf("vec%0d", i), tbl[i].d, tbl[i].pin, tbl[i].pen, tbl[i].ptyp,
                   tbl[i].pbit, tbl[i].sbit, -1, tbl[i].edv, tbl[i].epe, tbl[i].ese, tbl[i].epd);
      exp_pd = 8'h00;
      // Short low glitch: start detected, then rejected at mid-bit.
      prescale = 6'd16;
      dv0 = n_dv; pe0 = n_pe; se0 = n_se; b0 = n_busy;
      repeat (4) begin
         @(negedge clk);
         rx_in = 1'b0;
      end
      idle(40);
      check("glitch.busy_seen", n_busy > b0, 1);
      check("glitch.busy", busy, 0);
      check("glitch.pulses", (n_dv - dv0) + (n_pe - pe0) + (n_se - se0), 0);
      model_frame("after_glitch", 8'h6B, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, -1);
      // Break: line stays low well past the stop bit.
      dv0 = n_dv; se0 = n_se;
      par_en = 1'b0;
      send_frame(8'h81, 16, 1'b0, 1'b0, 1'b0, -1);
      send_bit(1'b0, 48, -1);
      idle(48);
      check("break.se", n_se - se0, 1);
      check("break.dv", n_dv - dv0, 0);
      check("break.busy", busy, 0);
      // Back-to-back frames with odd parity.
      dv0 = n_dv; pe0 = n_pe; se0 = n_se; q0 = pd_q.size();
      prescale = 6'd16; par_en = 1'b1; par_typ = 1'b1;
      send_frame(8'h55, 16, 1'b1, 1'b1, 1'b1, -1);
      send_frame(8'hAA, 16, 1'b1, 1'b1, 1'b1, -1);
      idle(48);
      check("b2b.dv", n_dv - dv0, 2);
      check("b2b.err", (n_pe - pe0) + (n_se - se0), 0);
      check("b2b.first", pd_q.size() > q0 ? pd_q[q0] : 8'hxx, 8'h55);
      check("b2b.second", pd_q.size() > q0 + 1 ? pd_q[q0 + 1] : 8'hxx, 8'hAA);
      exp_pd = 8'hAA;
      // Reset in the middle of data bit 4.
      dv0 = n_dv; pe0 = n_pe; se0 = n_se;
      par_en = 1'b0;
      send_bit(1'b0, 16, -1);
      for (int i = 0; i < 4; i++) send_bit(i[0] ? 1'b1 : 1'b1, 16, -1);
      send_bit(1'b1, 8, -1);
      #2 rst = 1'b1;
      #1;
      check("midrst.busy", busy, 0);
      check("midrst.pd", p_data, 0);
      check("midrst.pulses", {data_valid, par_err, stp_err}, 0);
      @(negedge clk);
      rst = 1'b0;
      idle(5);
      check("midrst.nopulse", (n_dv - dv0) + (n_pe - pe0) + (n_se - se0), 0);
      exp_pd = 8'h00;
      model_frame("after_rst", 8'h0F, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, -1);
      // A one-cycle flip away from the sampling window never matters.
      model_frame("flip_edge", 8'h96, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, 2);
`ifdef UART_RX_MAJORITY_EN
      model_frame("flip_mid", 8'h96, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, 9);
`endif
      for (int n = 0; n < 40; n++) begin
         logic [7:0] d;
         logic [5:0] pin;
         logic pen, ptyp, pbit, sbit;
         d = 8'($urandom);
         pin = 6'($urandom_range(0, 34));
         pen = 1'($urandom);
         ptyp = 1'($urandom);
         pbit = (^d) ^ ptyp ^ ($urandom_range(0, 4) == 0);
         sbit = $urandom_range(0, 6) != 0;
         model_frame($sformatf("rnd%0d", n), d, pin, pen, ptyp, pbit, sbit, -1);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: number of data bits per frame.
REQ-002 The block SHALL have port clk, input, 1: single clock; oversampling clock, prescale ticks per bit.
REQ-003 The block SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 The block SHALL have port rx_in, input, 1: serial line, idle high, asynchronous to clk.
REQ-005 The block SHALL have port prescale, input, 6: clk cycles per bit; legal 8..32 even; <8 treated as 8; odd rounded down.
REQ-006 The block SHALL have port par_en, input, 1: 1 = frame carries parity bit.
REQ-007 The block SHALL have port par_typ, input, 1: 0 = even, 1 = odd.
REQ-008 The block SHALL have port p_data, output, DATA_WIDTH: received data, LSB first on the line.
REQ-009 The block SHALL have port data_valid, output, 1: one-cycle pulse, p_data valid and frame error-free.
REQ-010 The block SHALL have port par_err, output, 1: one-cycle pulse, parity mismatch.
REQ-011 The block SHALL have port stp_err, output, 1: one-cycle pulse, stop bit sampled low.
REQ-012 The block SHALL have port busy, output, 1: high from start-bit detection until frame end.

Function
REQ-013 rx_in SHALL pass a 2-flop synchronizer (reset value 1) before any use; all latencies below count from the synchronized signal.
REQ-014 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-015 IDLE->START SHALL occur on the first cycle synchronized rx is 0; the edge counter is cleared to 0.
REQ-016 The edge counter SHALL count 0..prescale-1 per bit and wrap to 0, advancing the bit counter on wrap.
REQ-017 The sampled bit value SHALL be taken at edge count prescale/2 (decision available the following cycle).
REQ-018 In START, a sampled 1 SHALL be treated as a glitch: return to IDLE, no outputs pulsed, busy drops.
REQ-019 START->DATA SHALL occur at edge-count wrap; DATA captures DATA_WIDTH bits LSB first into a shift register.
REQ-020 After the last data bit, DATA SHALL go to PARITY if par_en=1, else to STOP; par_en/par_typ/prescale are latched at START entry and ignored mid-frame.
REQ-021 Expected parity SHALL be XOR of data bits when par_typ=0, inverted XOR when par_typ=1.
REQ-022 In STOP, one cycle after the stop-bit sample, exactly one outcome SHALL pulse: data_valid (no errors), else par_err and/or stp_err (both may pulse together).
REQ-023 p_data SHALL update only in the data_valid cycle and hold otherwise; errored frames do not change p_data.
REQ-024 The FSM SHALL return to IDLE in the cycle after the outcome pulse (mid stop bit), so a start edge arriving half a bit later is caught.
REQ-025 busy SHALL be 1 in START, DATA, PARITY, STOP; 0 in IDLE.
REQ-026 A line held low through STOP (break) SHALL produce stp_err, then no new frame until rx returns high for at least one cycle.

Reset
REQ-027 On rst=1, state SHALL go to IDLE immediately; counters 0; p_data 0; data_valid, par_err, stp_err, busy 0; synchronizer 1.
REQ-028 Reset mid-frame SHALL discard the partial frame with no output pulse.

Configuration
REQ-029 Macro UART_RX_MAJORITY_EN defined: each bit value SHALL be the 2-of-3 majority of samples at edge counts prescale/2-1, prescale/2, prescale/2+1.
REQ-030 Macro UART_RX_MAJORITY_EN undefined: single sample at prescale/2, no vote logic generated; latency is identical in both builds.

Verification
REQ-031 prescale=16, par_en=0, send 0xA5 with stop=1 -> one data_valid pulse, p_data=0xA5, no error pulses.
REQ-032 prescale=8, par_en=1, par_typ=0, send 0x3C with parity bit 1 -> par_err pulse, no data_valid, p_data unchanged.
REQ-033 prescale=16, send 0x81 with stop bit 0 -> stp_err pulse, no data_valid; line high afterward -> back to IDLE.
REQ-034 rx_in low for 4 cycles only (prescale=16) -> busy high then low, no pulses, FSM back in IDLE.
REQ-035 Back-to-back frames 0x55 then 0xAA with par_en=1, par_typ=1 -> two data_valid pulses, p_data 0x55 then 0xAA.
REQ-036 Assert rst during bit 4 of a frame -> all outputs 0 immediately; next full frame 0x0F -> data_valid, p_data=0x0F; with UART_RX_MAJORITY_EN, a one-cycle flip at prescale/2 does not corrupt the bit.
